ncl_mult3_sync_bridge: RTL and testbench

NCL_MULT3_SYNC_BRIDGE -- requirements
Module: ncl_mult3_sync_bridge

---
 rtl/ncl_mult3_pkg.sv | 50 +++++
 rtl/ncl_sync_bit.sv | 31 +++
 rtl/ncl_mult3_sync_bridge.sv | 196 +++++++++++++++++++
 tb/tb_ncl_mult3_sync_bridge.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ncl_mult3_pkg.sv
// Shared types and helpers for the clocked bridge to the NCL_MULT3 dual-rail multiplier.
// Each rail pair is {rail1, rail0}.
package ncl_mult3_pkg;

    localparam int OPND_W = 3;
    localparam int PROD_W = 6;
    localparam int TIMEOUT_CYC_DEFAULT = 64;

    localparam logic [1:0] RAIL_NULL    = 2'b00;
    localparam logic [1:0] RAIL_ZERO    = 2'b01;
    localparam logic [1:0] RAIL_ONE     = 2'b10;
    localparam logic [1:0] RAIL_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DRIVE_DATA = 3'd1,
        ST_WAIT_DATA  = 3'd2,
        ST_DRIVE_NULL = 3'd3,
        ST_WAIT_NULL  = 3'd4
    } state_e;

    // True when every pair of the product word carries a valid 0 or 1.
    function automatic logic word_is_data(input logic [PROD_W-1:0] r1, input logic [PROD_W-1:0] r0);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < PROD_W; i++) begin
            if (!({r1[i], r0[i]} == RAIL_ONE || {r1[i], r0[i]} == RAIL_ZERO)) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic word_is_null(input logic [PROD_W-1:0] r1, input logic [PROD_W-1:0] r0);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < PROD_W; i++) begin
            if ({r1[i], r0[i]} != RAIL_NULL) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic word_has_illegal(input logic [PROD_W-1:0] r1, input logic [PROD_W-1:0] r0);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < PROD_W; i++) begin
            if ({r1[i], r0[i]} == RAIL_ILLEGAL) bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/ncl_sync_bit.sv
// Multi-flop synchronizer for one asynchronous bit; q_o is the oldest stage.
module ncl_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d[0] = d_i;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ncl_mult3_sync_bridge.sv
// Clocked valid/ready front end for the NCL_MULT3 dual-rail multiplier: runs the
// DATA/NULL four-phase cycle and buffers one binary product.
module ncl_mult3_sync_bridge
    import ncl_mult3_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPND_W-1:0] a_in,
    input  logic [OPND_W-1:0] b_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [PROD_W-1:0] prod_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OPND_W-1:0] Ai_rail1,
    output logic [OPND_W-1:0] Ai_rail0,
    output logic [OPND_W-1:0] Bi_rail1,
    output logic [OPND_W-1:0] Bi_rail0,
    output logic              Ki,
    input  logic [PROD_W-1:0] Po_rail1,
    input  logic [PROD_W-1:0] Po_rail0,
    input  logic              Ko,
    output logic              err_illegal,
    output logic              err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);

    state_e             state_q, state_d;
    logic [OPND_W-1:0]  ai1_q, ai1_d, ai0_q, ai0_d;
    logic [OPND_W-1:0]  bi1_q, bi1_d, bi0_q, bi0_d;
    logic               ki_q, ki_d;
    logic [PROD_W-1:0]  prod_q, prod_d;
    logic               out_valid_q, out_valid_d;
    logic               err_ill_q, err_ill_d;
    logic               err_to_q, err_to_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] flush_q, flush_d;

    logic               ko_s;
    logic [PROD_W-1:0]  po1_s, po0_s;

    ncl_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ko (
        .clk (clk),
        .rst (rst),
        .d_i (Ko),
        .q_o (ko_s)
    );

    for (genvar i = 0; i < PROD_W; i++) begin : g_po_sync
        ncl_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_r1 (
            .clk (clk),
            .rst (rst),
            .d_i (Po_rail1[i]),
            .q_o (po1_s[i])
        );
        ncl_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_r0 (
            .clk (clk),
            .rst (rst),
            .d_i (Po_rail0[i]),
            .q_o (po0_s[i])
        );
    end

    logic data_done, null_done, illegal_seen, in_wait;
    logic capture, drain, stall, cnt_hit, flushed;

    assign data_done    = ko_s && word_is_data(po1_s, po0_s);
    assign null_done    = !ko_s && word_is_null(po1_s, po0_s);
    assign illegal_seen = word_has_illegal(po1_s, po0_s);
    assign in_wait      = (state_q == ST_WAIT_DATA) || (state_q == ST_WAIT_NULL);
    assign drain        = out_valid_q && out_ready;
    assign capture      = (state_q == ST_WAIT_DATA) && data_done && (!out_valid_q || out_ready);
    assign stall        = (state_q == ST_WAIT_DATA) && data_done && !capture;
    assign cnt_hit      = (cnt_q + CNT_W'(1)) == CNT_LIMIT;

    // The synchronizers read 0 straight out of reset, so a low Ko only means
    // something once real samples have reached the last stage.
    assign flushed  = flush_q[SYNC_STAGES-1];
    assign in_ready = (state_q == ST_IDLE) && !rst && flushed && !ko_s;

    always_comb begin
        state_d     = state_q;
        ai1_d       = ai1_q;
        ai0_d       = ai0_q;
        bi1_d       = bi1_q;
        bi0_d       = bi0_q;
        ki_d        = ki_q;
        prod_d      = prod_q;
        out_valid_d = out_valid_q;
        err_ill_d   = err_ill_q;
        err_to_d    = err_to_q;
        cnt_d       = cnt_q;
        flush_d     = (flush_q << 1) | SYNC_STAGES'(1);

        if (drain) out_valid_d = 1'b0;
        if (in_wait && illegal_seen) err_ill_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    ai1_d   = a_in;
                    ai0_d   = ~a_in;
                    bi1_d   = b_in;
                    bi0_d   = ~b_in;
                    ki_d    = 1'b1;
                    state_d = ST_DRIVE_DATA;
                end
            end
            ST_DRIVE_DATA: begin
                cnt_d   = '0;
                state_d = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                if (capture || (!stall && cnt_hit)) begin
                    ai1_d   = '0;
                    ai0_d   = '0;
                    bi1_d   = '0;
                    bi0_d   = '0;
                    ki_d    = 1'b0;
                    state_d = ST_DRIVE_NULL;
                end
                if (capture) begin
                    prod_d      = po1_s;
                    out_valid_d = 1'b1;
                end else if (!stall) begin
                    if (cnt_hit) err_to_d = 1'b1;
                    else         cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            ST_DRIVE_NULL: begin
                cnt_d   = '0;
                state_d = ST_WAIT_NULL;
            end
            ST_WAIT_NULL: begin
                if (null_done) begin
                    state_d = ST_IDLE;
                end else if (cnt_hit) begin
                    err_to_d = 1'b1;
                    state_d  = ST_DRIVE_NULL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ai1_q       <= '0;
            ai0_q       <= '0;
            bi1_q       <= '0;
            bi0_q       <= '0;
            ki_q        <= 1'b0;
            prod_q      <= '0;
            out_valid_q <= 1'b0;
            err_ill_q   <= 1'b0;
            err_to_q    <= 1'b0;
            cnt_q       <= '0;
            flush_q     <= '0;
        end else begin
            state_q     <= state_d;
            ai1_q       <= ai1_d;
            ai0_q       <= ai0_d;
            bi1_q       <= bi1_d;
            bi0_q       <= bi0_d;
            ki_q        <= ki_d;
            prod_q      <= prod_d;
            out_valid_q <= out_valid_d;
            err_ill_q   <= err_ill_d;
            err_to_q    <= err_to_d;
            cnt_q       <= cnt_d;
            flush_q     <= flush_d;
        end
    end

    // Rails and Ki come straight from flops so the asynchronous side never sees a glitch.
    assign Ai_rail1    = ai1_q;
    assign Ai_rail0    = ai0_q;
    assign Bi_rail1    = bi1_q;
    assign Bi_rail0    = bi0_q;
    assign Ki          = ki_q;
    assign prod_out    = prod_q;
    assign out_valid   = out_valid_q;
    assign err_illegal = err_ill_q;
    assign err_timeout = err_to_q;

endmodule

// File: tb/tb_ncl_mult3_sync_bridge.sv
// Bench for ncl_mult3_sync_bridge with a delayed behavioural NCL_MULT3 stand-in.
module tb_ncl_mult3_sync_bridge;

    logic       clk;
    logic       rst;
    logic [2:0] a_in;
    logic [2:0] b_in;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] prod_out;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] Ai_rail1, Ai_rail0, Bi_rail1, Bi_rail0;
    logic       Ki;
    logic [5:0] Po_rail1 = '0;
    logic [5:0] Po_rail0 = '0;
    logic       Ko = 1'b0;
    logic       err_illegal;
    logic       err_timeout;

    ncl_mult3_sync_bridge dut (
        .clk         (clk),
        .rst         (rst),
        .a_in        (a_in),
        .b_in        (b_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .prod_out    (prod_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .Ai_rail1    (Ai_rail1),
        .Ai_rail0    (Ai_rail0),
        .Bi_rail1    (Bi_rail1),
        .Bi_rail0    (Bi_rail0),
        .Ki          (Ki),
        .Po_rail1    (Po_rail1),
        .Po_rail0    (Po_rail0),
        .Ko          (Ko),
        .err_illegal (err_illegal),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // NCL_MULT3 stand-in: 0 = normal, 1 = never raises Ko, 2 = product bit 2 forced to 11.
    int   mode = 0;
    int   m_cnt = 0;
    int   m_dly = 2;
    logic m_is_data = 1'b0;
    logic m_in_data, m_in_null;
    logic [5:0] m_prod;

    assign m_in_data = Ki && ((Ai_rail1 ^ Ai_rail0) == 3'b111) && ((Bi_rail1 ^ Bi_rail0) == 3'b111);
    assign m_in_null = !Ki && (Ai_rail1 == 3'b000) && (Ai_rail0 == 3'b000)
                       && (Bi_rail1 == 3'b000) && (Bi_rail0 == 3'b000);
    assign m_prod = {3'b000, Ai_rail1} * {3'b000, Bi_rail1};

    always @(posedge clk) begin
        if ((m_in_data && !m_is_data) || (m_in_null && m_is_data)) begin
            if (m_cnt >= m_dly) begin
                m_cnt <= 0;
                m_dly <= $urandom_range(0, 3);
                if (m_in_data) begin
                    m_is_data <= 1'b1;
                    Po_rail1  <= (mode == 2) ? (m_prod | 6'b000100) : m_prod;
                    Po_rail0  <= (mode == 2) ? (~m_prod | 6'b000100) : ~m_prod;
                    Ko        <= (mode != 1);
                end else begin
                    m_is_data <= 1'b0;
                    Po_rail1  <= '0;
                    Po_rail0  <= '0;
                    Ko        <= 1'b0;
                end
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else begin
            m_cnt <= 0;
        end
    end

    int   n_checks = 0;
    int   n_pass = 0;
    bit   rand_ready = 0;
    logic [5:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Offer one pair and hold it until accepted; the expected product is queued on accept.
    task automatic send(input logic [2:0] a, input logic [2:0] b, input bit expect_res);
        bit done;
        done = 0;
        a_in = a;
        b_in = b;
        in_valid = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            if (in_ready === 1'b1) begin
                if (expect_res) exp_q.push_back({3'b000, a} * {3'b000, b});
                done = 1;
            end
            tick();
        end
        in_valid = 1'b0;
        check("accept", 32'(done), 32'd1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 100 && out_valid !== 1'b1; i++) tick();
        check("valid_seen", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 600 && (exp_q.size() != 0 || out_valid === 1'b1); i++) tick();
        check("drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_ki"}, 32'(Ki), 32'd0);
        check({tag, "_rails"}, 32'({Ai_rail1, Ai_rail0, Bi_rail1, Bi_rail0}), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_prod"}, 32'(prod_out), 32'd0);
        check({tag, "_errs"}, 32'({err_illegal, err_timeout}), 32'd0);
    endtask

    // Scoreboard: every handshake on the output must match the oldest expected product.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(prod_out), 32'hffff_ffff);
            end else begin
                check("result", 32'(prod_out), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        a_in = '0;
        b_in = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single transaction 5*4 with the Ki DATA/NULL sequence.
        send(3'd5, 3'd4, 1);
        check("dd_ki", 32'(Ki), 32'd1);
        check("dd_a_rails", 32'({Ai_rail1, Ai_rail0}), 32'({3'd5, 3'd2}));
        check("dd_b_rails", 32'({Bi_rail1, Bi_rail0}), 32'({3'd4, 3'd3}));
        wait_valid();
        check("cap_prod", 32'(prod_out), 32'd20);
        check("cap_ki_null", 32'(Ki), 32'd0);
        tick();
        check("one_pulse", 32'(out_valid), 32'd0);
        wait_drain();

        // Back-to-back pairs with the consumer always ready.
        send(3'd6, 3'd7, 1);
        check("busy_in_ready", 32'(in_ready), 32'd0);
        send(3'd7, 3'd1, 1);
        wait_drain();

        // Full buffer: second result must stall in WAIT_DATA without timing out.
        out_ready = 1'b0;
        send(3'd6, 3'd7, 1);
        wait_valid();
        send(3'd7, 3'd1, 1);
        repeat (80) tick();
        check("stall_ki", 32'(Ki), 32'd1);
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_prod", 32'(prod_out), 32'd42);
        check("stall_no_timeout", 32'(err_timeout), 32'd0);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        wait_drain();

        // Random operands with a randomly throttled consumer.
        rand_ready = 1;
        for (int i = 0; i < 24; i++) begin
            send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1);
        end
        rand_ready = 0;
        out_ready = 1'b1;
        wait_drain();
        check("no_errors", 32'({err_illegal, err_timeout}), 32'd0);

        // Ko never rises: timeout after exactly TIMEOUT_CYC wait cycles.
        mode = 1;
        send(3'd2, 3'd5, 0);
        repeat (64) tick();
        check("to_before", 32'(err_timeout), 32'd0);
        check("to_before_ki", 32'(Ki), 32'd1);
        tick();
        check("to_after", 32'(err_timeout), 32'd1);
        check("to_rails_null", 32'({Ki, Ai_rail1, Ai_rail0, Bi_rail1, Bi_rail0}), 32'd0);
        for (int i = 0; i < 100 && in_ready !== 1'b1; i++) tick();
        check("to_idle", 32'(in_ready), 32'd1);
        check("to_no_capture", 32'(out_valid), 32'd0);
        check("to_no_illegal", 32'(err_illegal), 32'd0);

        // Reset in the middle of WAIT_DATA.
        send(3'd2, 3'd2, 0);
        repeat (4) tick();
        check("pre_rst_ki", 32'(Ki), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        tick();
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        mode = 0;
        tick();
        check("post_rst_hold", 32'(in_ready), 32'd0);
        send(3'd3, 3'd3, 1);
        wait_valid();
        check("post_rst_prod", 32'(prod_out), 32'd9);
        wait_drain();

        // Illegal pair on product bit 2: flagged, never captured, recovered by timeout.
        mode = 2;
        send(3'd5, 3'd3, 0);
        for (int i = 0; i < 30 && err_illegal !== 1'b1; i++) tick();
        check("ill_flag", 32'(err_illegal), 32'd1);
        check("ill_no_capture", 32'(out_valid), 32'd0);
        for (int i = 0; i < 200 && in_ready !== 1'b1; i++) tick();
        check("ill_idle", 32'(in_ready), 32'd1);
        check("ill_timeout", 32'(err_timeout), 32'd1);
        check("ill_still_empty", 32'(out_valid), 32'd0);
        mode = 0;
        send(3'd7, 3'd7, 1);
        wait_drain();
        check("sticky_errs", 32'({err_illegal, err_timeout}), 32'd3);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
